// File: rtl/vc_fifo_bank.sv
// Multi-VC input buffer: NUM_VC FIFOs sharing one storage array, with per-VC
// occupancy flags, registered credit return and sticky protocol-error flags.
module vc_fifo_bank #(
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 4,
   parameter int NUM_VC       = 2,
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int PTR_W = $clog2(BUFFER_DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write_strobe_din,
   input  logic [VC_W-1:0]           write_vc_din,
   input  logic [DATA_WIDTH-1:0]     write_data_din,
   input  logic                      read_strobe_din,
   input  logic [VC_W-1:0]           read_vc_din,
   output logic [DATA_WIDTH-1:0]     read_data_dout,
   output logic [NUM_VC-1:0]         full_dout,
   output logic [NUM_VC-1:0]         empty_dout,
   output logic [NUM_VC*CNT_W-1:0]   count_dout,
   output logic                      credit_valid_dout,
   output logic [VC_W-1:0]           credit_vc_dout,
   output logic                      overflow_dout,
   output logic                      underflow_dout
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

   logic [DATA_WIDTH-1:0] mem [NUM_VC*BUFFER_DEPTH];
   logic [CNT_W-1:0]      cnt    [NUM_VC];
   logic [PTR_W-1:0]      wr_ptr [NUM_VC];
   logic [PTR_W-1:0]      rd_ptr [NUM_VC];

   logic [VC_W-1:0]   wr_vc, rd_vc;
   logic              wr_vc_ok, rd_vc_ok;
   logic              wr_acc, rd_acc;
   logic [NUM_VC-1:0] wr_oh, rd_oh;

   // Out-of-range indices are steered to VC 0 only to keep array reads in bounds;
   // the *_ok terms make sure such operations are never accepted.
   always_comb begin
      wr_vc    = '0;
      rd_vc    = '0;
      wr_vc_ok = 1'b1;
      rd_vc_ok = 1'b1;
      if (NUM_VC > 1) begin
         wr_vc_ok = (int'(write_vc_din) < NUM_VC);
         rd_vc_ok = (int'(read_vc_din) < NUM_VC);
         if (wr_vc_ok) wr_vc = write_vc_din;
         if (rd_vc_ok) rd_vc = read_vc_din;
      end
      wr_acc = write_strobe_din && wr_vc_ok && (cnt[wr_vc] != FULL_CNT);
      rd_acc = read_strobe_din  && rd_vc_ok && (cnt[rd_vc] != '0);
      wr_oh  = '0;
      rd_oh  = '0;
      if (wr_acc) wr_oh[wr_vc] = 1'b1;
      if (rd_acc) rd_oh[rd_vc] = 1'b1;
   end

   always_comb begin
      full_dout  = '0;
      empty_dout = '0;
      count_dout = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         full_dout[v]                  = (cnt[v] == FULL_CNT);
         empty_dout[v]                 = (cnt[v] == '0);
         count_dout[v*CNT_W +: CNT_W]  = cnt[v];
      end
   end

   assign read_data_dout = mem[{rd_vc, rd_ptr[rd_vc]}];

   // Storage is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc)
         mem[{wr_vc, wr_ptr[wr_vc]}] <= write_data_din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < NUM_VC; v++) begin
            cnt[v]    <= '0;
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
         end
         credit_valid_dout <= 1'b0;
         credit_vc_dout    <= '0;
         overflow_dout     <= 1'b0;
         underflow_dout    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr[wr_vc] <= wr_ptr[wr_vc] + 1'b1;
         if (rd_acc) rd_ptr[rd_vc] <= rd_ptr[rd_vc] + 1'b1;
         for (int v = 0; v < NUM_VC; v++) begin
            if (wr_oh[v] && !rd_oh[v])
               cnt[v] <= cnt[v] + 1'b1;
            else if (rd_oh[v] && !wr_oh[v])
               cnt[v] <= cnt[v] - 1'b1;
         end
         credit_valid_dout <= rd_acc;
         if (rd_acc) credit_vc_dout <= rd_vc;
         if (write_strobe_din && !wr_acc) overflow_dout  <= 1'b1;
         if (read_strobe_din  && !rd_acc) underflow_dout <= 1'b1;
      end
   end

endmodule
